pong_input_conditioner: RTL and testbench

- Input front end for the pong game: conditions the raw start button and the four IR sensor pins before they reach the game-level state machine and gameplay logic.
- Per channel: 2-flop synchronizer, counter-based debounce, and single-cycle rise/fall pulses.
- Also produces `ir_all`, the AND of the three debounced paddle sensors, for the game-level consumer.
- Sits directly upstream of the game-level state machine; its outputs replace the raw pins at that boundary.

---
 rtl/pong_input_pkg.sv | 16 +
 rtl/debounce_channel.sv | 78 +++++++
 rtl/pong_input_conditioner.sv | 93 +++++++++
 tb/tb_pong_input_conditioner.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pong_input_pkg.sv
// Shared types, defaults and width helper for the pong input conditioner.
package pong_input_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } db_state_e;

  localparam int unsigned DEFAULT_DB_CYCLES   = 1_000_000;
  localparam int unsigned DEFAULT_LONG_CYCLES = 200_000_000;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One input channel: 2-flop synchronizer, counter debounce, one-cycle rise/fall pulses.
module debounce_channel
  import pong_input_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEFAULT_DB_CYCLES
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned   CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("debounce_channel: DB_CYCLES must be at least 2");
  end

  logic          s1, s2;
  db_state_e     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          level_n, rise_n, fall_n;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= ST_STABLE;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= din;
      s2    <= s1;
      state <= state_n;
      cnt   <= cnt_n;
      level <= level_n;
      rise  <= rise_n;
      fall  <= fall_n;
    end
  end

  // Any return of s2 to the accepted level during counting discards the run.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    level_n = level;
    rise_n  = 1'b0;
    fall_n  = 1'b0;
    unique case (state)
      ST_STABLE: begin
        if (s2 != level) begin
          state_n = ST_COUNT;
          cnt_n   = CW'(1);
        end
      end
      ST_COUNT: begin
        if (s2 == level) begin
          state_n = ST_STABLE;
          cnt_n   = '0;
        end else if (cnt == CNT_LAST) begin
          state_n = ST_STABLE;
          cnt_n   = '0;
          level_n = s2;
          rise_n  = s2;
          fall_n  = ~s2;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/pong_input_conditioner.sv
// Debounced start button and IR sensors for the pong game FSM.
// Optional long-press detector on start is enabled by defining START_LONG_EN.
module pong_input_conditioner
  import pong_input_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEFAULT_DB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEFAULT_LONG_CYCLES
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic start_btn_raw,
  input  logic ir_sensor_1_raw,
  input  logic ir_sensor_2_raw,
  input  logic ir_sensor_3_raw,
  input  logic ir_sensor2_raw,
  output logic start_btn,
  output logic start_pulse,
  output logic ir_sensor_1,
  output logic ir_sensor_2,
  output logic ir_sensor_3,
  output logic ir_sensor2,
  output logic ir_all,
  output logic ir2_rise,
  output logic start_long
);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("pong_input_conditioner: LONG_CYCLES must be at least 2");
  end

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_start (
    .clk_100MHz(clk_100MHz), .reset(reset), .din(start_btn_raw),
    .level(start_btn), .rise(start_pulse), .fall()
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ir1 (
    .clk_100MHz(clk_100MHz), .reset(reset), .din(ir_sensor_1_raw),
    .level(ir_sensor_1), .rise(), .fall()
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ir2 (
    .clk_100MHz(clk_100MHz), .reset(reset), .din(ir_sensor_2_raw),
    .level(ir_sensor_2), .rise(), .fall()
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ir3 (
    .clk_100MHz(clk_100MHz), .reset(reset), .din(ir_sensor_3_raw),
    .level(ir_sensor_3), .rise(), .fall()
  );

  debounce_channel #(.DB_CYCLES(DB_CYCLES)) u_ir_p2 (
    .clk_100MHz(clk_100MHz), .reset(reset), .din(ir_sensor2_raw),
    .level(ir_sensor2), .rise(ir2_rise), .fall()
  );

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) ir_all <= 1'b0;
    else       ir_all <= ir_sensor_1 & ir_sensor_2 & ir_sensor_3;
  end

`ifdef START_LONG_EN
  localparam int unsigned   LW        = cnt_width(LONG_CYCLES);
  localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] hold_cnt;
  logic          hold_done;

  // hold_done blocks repeats until the debounced button is released.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      hold_cnt   <= '0;
      hold_done  <= 1'b0;
      start_long <= 1'b0;
    end else begin
      start_long <= 1'b0;
      if (!start_btn) begin
        hold_cnt  <= '0;
        hold_done <= 1'b0;
      end else if (!hold_done) begin
        if (hold_cnt == HOLD_LAST) begin
          start_long <= 1'b1;
          hold_done  <= 1'b1;
        end else begin
          hold_cnt <= hold_cnt + 1'b1;
        end
      end
    end
  end
`else
  assign start_long = 1'b0;
`endif

endmodule

// File: tb/tb_pong_input_conditioner.sv
// Directed self-checking bench for pong_input_conditioner (DB_CYCLES=16, LONG_CYCLES=64).
module tb_pong_input_conditioner;

  localparam int unsigned DB   = 16;
  localparam int unsigned LONG = 64;
`ifdef START_LONG_EN
  localparam logic LONG_ON = 1'b1;
`else
  localparam logic LONG_ON = 1'b0;
`endif

  logic clk_100MHz = 1'b0;
  logic reset = 1'b1;
  logic start_btn_raw = 1'b0, ir_sensor_1_raw = 1'b0, ir_sensor_2_raw = 1'b0;
  logic ir_sensor_3_raw = 1'b0, ir_sensor2_raw = 1'b0;
  logic start_btn, start_pulse, ir_sensor_1, ir_sensor_2, ir_sensor_3;
  logic ir_sensor2, ir_all, ir2_rise, start_long;

  int total = 0;
  int bad   = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  pong_input_conditioner #(.DB_CYCLES(DB), .LONG_CYCLES(LONG)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset),
    .start_btn_raw(start_btn_raw), .ir_sensor_1_raw(ir_sensor_1_raw),
    .ir_sensor_2_raw(ir_sensor_2_raw), .ir_sensor_3_raw(ir_sensor_3_raw),
    .ir_sensor2_raw(ir_sensor2_raw),
    .start_btn(start_btn), .start_pulse(start_pulse),
    .ir_sensor_1(ir_sensor_1), .ir_sensor_2(ir_sensor_2), .ir_sensor_3(ir_sensor_3),
    .ir_sensor2(ir_sensor2), .ir_all(ir_all), .ir2_rise(ir2_rise),
    .start_long(start_long)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One call = one rising edge passed, sampled on the following falling edge.
  task automatic edges(input int n);
    repeat (n) @(negedge clk_100MHz);
  endtask

  function automatic logic [8:0] all_outs();
    return {start_btn, start_pulse, ir_sensor_1, ir_sensor_2, ir_sensor_3,
            ir_sensor2, ir_all, ir2_rise, start_long};
  endfunction

  int cnt_hi;

  initial begin
    // 1: reset and idle
    edges(3);
    check("outs_in_reset", 32'(all_outs()), 32'h0);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      edges(1);
      if (i % 10 == 9) check("idle_outs", 32'(all_outs()), 32'h0);
    end

    // 2 + 6: start press, latency, long press
    start_btn_raw = 1'b1;
    edges(DB + 1);
    check("start_lvl_e17", 32'(start_btn), 32'h0);
    check("start_pls_e17", 32'(start_pulse), 32'h0);
    edges(1);
    check("start_lvl_e18", 32'(start_btn), 32'h1);
    check("start_pls_e18", 32'(start_pulse), 32'h1);
    edges(1);
    check("start_pls_e19", 32'(start_pulse), 32'h0);
    check("start_lvl_e19", 32'(start_btn), 32'h1);
    edges(LONG - 2);
    check("long_before", 32'(start_long), 32'h0);
    edges(1);
    check("long_at_64", 32'(start_long), 32'(LONG_ON));
    cnt_hi = 0;
    for (int i = 0; i < 118; i++) begin
      edges(1);
      if (start_long || start_pulse) cnt_hi++;
    end
    check("long_no_repeat", 32'(cnt_hi), 32'h0);
    start_btn_raw = 1'b0;
    edges(DB + 1);
    check("start_hold_e17", 32'(start_btn), 32'h1);
    edges(1);
    check("start_fall_e18", 32'(start_btn), 32'h0);
    start_btn_raw = 1'b1;
    edges(DB + 2);
    check("repress_lvl", 32'(start_btn), 32'h1);
    check("repress_pls", 32'(start_pulse), 32'h1);
    cnt_hi = 0;
    for (int i = 0; i < int'(LONG) - 1; i++) begin
      edges(1);
      if (start_long) cnt_hi++;
    end
    check("relong_early", 32'(cnt_hi), 32'h0);
    edges(1);
    check("relong_at_64", 32'(start_long), 32'(LONG_ON));
    start_btn_raw = 1'b0;
    edges(40);
    check("start_released", 32'(start_btn), 32'h0);

    // 3: glitch rejection then minimum accepted hold
    ir_sensor_1_raw = 1'b1;
    edges(10);
    ir_sensor_1_raw = 1'b0;
    cnt_hi = 0;
    for (int i = 0; i < 30; i++) begin
      edges(1);
      if (ir_sensor_1) cnt_hi++;
    end
    check("glitch_rejected", 32'(cnt_hi), 32'h0);
    ir_sensor_1_raw = 1'b1;
    edges(DB);
    ir_sensor_1_raw = 1'b0;
    edges(1);
    check("ir1_e17", 32'(ir_sensor_1), 32'h0);
    edges(1);
    check("ir1_e18", 32'(ir_sensor_1), 32'h1);
    edges(40);
    check("ir1_dropped", 32'(ir_sensor_1), 32'h0);

    // 4: paddle sensors together, ir_all lag
    {ir_sensor_1_raw, ir_sensor_2_raw, ir_sensor_3_raw} = 3'b111;
    edges(DB + 1);
    check("paddles_e17", 32'({ir_sensor_1, ir_sensor_2, ir_sensor_3}), 32'h0);
    edges(1);
    check("paddles_e18", 32'({ir_sensor_1, ir_sensor_2, ir_sensor_3, ir_all}), 32'he);
    edges(1);
    check("ir_all_e19", 32'(ir_all), 32'h1);
    ir_sensor_2_raw = 1'b0;
    edges(DB + 2);
    check("drop_e18", 32'({ir_sensor_2, ir_all}), 32'h1);
    edges(1);
    check("drop_e19", 32'(ir_all), 32'h0);
    {ir_sensor_1_raw, ir_sensor_3_raw} = 2'b00;
    edges(40);

    // 5: reset in the middle of a count
    ir_sensor2_raw = 1'b1;
    edges(10);
    reset = 1'b1;
    #1;
    check("ir2_in_reset", 32'({ir_sensor2, ir2_rise}), 32'h0);
    edges(5);
    check("ir2_reset_end", 32'({ir_sensor2, ir2_rise}), 32'h0);
    reset = 1'b0;
    edges(DB + 1);
    check("ir2_rise_e17", 32'({ir_sensor2, ir2_rise}), 32'h0);
    edges(1);
    check("ir2_rise_e18", 32'({ir_sensor2, ir2_rise}), 32'h3);
    edges(1);
    check("ir2_rise_e19", 32'({ir_sensor2, ir2_rise}), 32'h2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
